dphy_rx_model: RTL
==================

# dphy_rx_model

Behavioural D-PHY receive-side model for the two-lane CSI-2 link. It watches the abstracted PHY pins driven by the transmit model (HS clock gate, HS data-active flag, 2-bit per-lane symbols) and skips HS-SETTLE. It then hunts for the SoT sync byte on each lane, deserialises 2-bit symbols into bytes and presents byte-aligned data to the CSI-2 receive controller. It also flags SoT errors and enforces HS-EXIT before the next burst.

## Interface
- SETTLE_CYC, 6: byteclk cycles ignored after HS clock becomes active
- EXIT_CYC, 4: minimum byteclk cycles in EXIT before re-arming
- SYNC_TIMEOUT, 32: cycles allowed in SYNC before errsoths_hs
- SYNC_BYTE, 8'hB8: SoT sync pattern, LSB-first
- byteclk  input  1  sole clock, all logic on rising edge
- resetn  input  1  synchronous active-low reset
- hs_clk_active  input  1  HS clock running
- hs_active  input  1  HS data state on the line
- D0  input  2  lane0 symbol, bit0 is earlier bit
- D1  input  2  lane1 symbol
- rxactive_hs  output  1  receiver in SYNC or HS
- rxsync_hs  output  1  one-cycle pulse when sync found on all enabled lanes
- rxvalid_hs  output  1  one-cycle pulse, lane bytes valid
- lane0_byte  output  8  lane0 received byte
- lane1_byte  output  8  lane1 received byte
- errsoths_hs  output  1  one-cycle pulse, sync timeout
- errsotsync_hs  output  1  one-cycle pulse, lanes synced in different cycles

## Operation
- All outputs reset to 0. The FSM resets to LP, and all counters and shift registers reset to 0.
- Per lane, a shift register updates every cycle in SYNC/HS: sr <= {Dx, sr[7:2]}.
- States and transitions:
  - LP: outputs idle. hs_clk_active && hs_active -> SETTLE, with settle_cnt loaded to SETTLE_CYC.
  - SETTLE: settle_cnt decrements and symbols are ignored. On reaching 0 -> SYNC, with shift registers and sync timer cleared.
  - SYNC: the updated sr is compared with SYNC_BYTE.
    - All enabled lanes match in the same cycle -> HS, pulse rxsync_hs, sym_cnt=0.
    - Only a subset matches -> pulse errsotsync_hs, go to EXIT.
    - Timer reaches SYNC_TIMEOUT -> pulse errsoths_hs, go to EXIT.
  - HS: sym_cnt counts 0..3 per captured symbol. When the 4th symbol is captured, the assembled bytes are registered to laneX_byte and rxvalid_hs pulses next cycle. The counter wraps 3 -> 0.
  - EXIT: entered on hs_active low from SETTLE/SYNC/HS, or on error. Loads exit_cnt=EXIT_CYC. Holds while hs_active is high or exit_cnt>0, decrementing. -> LP when both are clear.
- A partial byte (sym_cnt≠0) at hs_active fall is discarded. rxvalid_hs never fires for it.
- laneX_byte holds its last value between rxvalid_hs pulses.
- rxactive_hs is registered: 1 in the cycle after entering SYNC, 0 in the cycle after entering EXIT.
- Resetn low in any state returns to LP on the next edge, dropping any in-flight byte.
- An hs_active fall in the same cycle as a sync match: the fall wins. No rxsync_hs pulse, go to EXIT.

## Timing
- SETTLE lasts exactly SETTLE_CYC cycles. Symbols are captured starting with the first SYNC cycle.
- rxsync_hs is asserted 1 cycle after the cycle in which the 4th sync symbol is sampled.
- Data bytes: rxvalid_hs is asserted 1 cycle after the sampling of each 4th symbol, so pulses are every 4 cycles with continuous data.
- Minimum LP-to-LP burst gap is EXIT_CYC+1 cycles after hs_active low.

## Configuration
- DPHY_RX_LANE1_EN defined:
  - Lane1 deserialiser is compiled in.
  - Sync requires both lanes.
  - lane1_byte is driven.
- Not defined:
  - Single-lane receiver.
  - D1 is ignored.
  - lane1_byte is tied to 0.
  - errsotsync_hs is tied to 0.

## Structure
- Shared package dphy_pkg holds:
  - the state enum (LP, SETTLE, SYNC, HS, EXIT), shared with the TX model
  - the default SYNC_BYTE constant
  - the symbol width constant (2)
- Sub-module dphy_rx_lane, instanced once per lane. It contains the shift register, the sync-match comparator and the byte-assembly register, with a clear input and a capture enable from the top FSM.

## Test plan
- Clean burst:
  - Stimulus: after 6 SETTLE cycles, D0=D1 sequence 00,10,11,10 (0xB8), then 01,00,00,00 and 11,11,11,11.
  - Response: rxsync_hs pulse, then rxvalid_hs with lane bytes 0x01, then 0xFF.
- Sync timeout: no 0xB8 for 32 SYNC cycles -> errsoths_hs pulse, EXIT, LP after hs_active low plus 4 cycles, no rxvalid_hs.
- Lane mismatch: lane0 sends 0xB8, lane1 sends 0x00 -> errsotsync_hs pulse, no rxsync_hs.
- Truncated byte: hs_active drops after 2 symbols of a byte -> no rxvalid_hs for it, rxactive_hs falls 1 cycle later.
- Reset mid-HS: resetn low for 1 cycle during a byte -> all outputs 0, FSM in LP, and the next burst receives correctly.
- Back-to-back: a new hs_active rise during EXIT is not accepted until exit_cnt reaches 0 and hs_active has been low.

Source files
------------

// File: rtl/dphy_pkg.sv
// Shared D-PHY definitions used by the RX and TX behavioural models:
// link state encoding, symbol width and the default SoT sync pattern.
package dphy_pkg;

  localparam int DPHY_SYM_W = 2;

  // SoT sync pattern, transmitted LSB-first.
  localparam logic [7:0] DPHY_SYNC_BYTE = 8'hB8;

  typedef enum logic [2:0] {
    DPHY_ST_LP     = 3'd0,
    DPHY_ST_SETTLE = 3'd1,
    DPHY_ST_SYNC   = 3'd2,
    DPHY_ST_HS     = 3'd3,
    DPHY_ST_EXIT   = 3'd4
  } dphy_state_t;

endpackage

// File: rtl/dphy_rx_lane.sv
// One D-PHY receive lane: 2-bit symbol shift register, SoT sync comparator
// and the byte register presented to the CSI-2 controller.
// Symbols enter at the top so the first symbol of a byte ends up in bits [1:0].
module dphy_rx_lane
  import dphy_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DPHY_SYNC_BYTE
) (
  input  logic                  byteclk,
  input  logic                  resetn,
  input  logic                  clr,
  input  logic                  cap_en,
  input  logic                  byte_en,
  input  logic [DPHY_SYM_W-1:0] d,
  output logic                  match,
  output logic [7:0]            lane_byte
);

  logic [7:0] sr;
  logic [7:0] sr_next;

  // Compare against the value the register takes this edge so a match is
  // seen in the same cycle the 4th sync symbol is sampled.
  assign sr_next = {d, sr[7:DPHY_SYM_W]};
  assign match   = (sr_next == SYNC_BYTE);

  // Shift register and byte capture.
  always_ff @(posedge byteclk) begin
    if (!resetn) begin
      sr        <= 8'h00;
      lane_byte <= 8'h00;
    end else begin
      if (clr) begin
        sr <= 8'h00;
      end else if (cap_en) begin
        sr <= sr_next;
      end
      if (byte_en) begin
        lane_byte <= sr_next;
      end
    end
  end

endmodule

// File: rtl/dphy_rx_model.sv
// Behavioural D-PHY receiver for the two-lane CSI-2 link.
// Skips HS-SETTLE, hunts for the SoT sync byte, deserialises 2-bit symbols
// into bytes and enforces HS-EXIT before the next burst.
// Build option: DPHY_RX_LANE1_EN compiles in lane1; without it the receiver
// is single-lane, D1 is ignored and lane1_byte / errsotsync_hs read 0.
//
// state  | meaning
// LP     | line idle, waiting for HS clock and HS data
// SETTLE | HS-SETTLE window, symbols ignored
// SYNC   | hunting for the SoT sync byte
// HS     | receiving payload, one byte every 4 symbols
// EXIT   | HS-EXIT hold-off before returning to LP
module dphy_rx_model
  import dphy_pkg::*;
#(
  parameter int         SETTLE_CYC   = 6,
  parameter int         EXIT_CYC     = 4,
  parameter int         SYNC_TIMEOUT = 32,
  parameter logic [7:0] SYNC_BYTE    = DPHY_SYNC_BYTE
) (
  input  logic                  byteclk,
  input  logic                  resetn,
  input  logic                  hs_clk_active,
  input  logic                  hs_active,
  input  logic [DPHY_SYM_W-1:0] D0,
  input  logic [DPHY_SYM_W-1:0] D1,
  output logic                  rxactive_hs,
  output logic                  rxsync_hs,
  output logic                  rxvalid_hs,
  output logic [7:0]            lane0_byte,
  output logic [7:0]            lane1_byte,
  output logic                  errsoths_hs,
  output logic                  errsotsync_hs
);

  dphy_state_t state;
  logic [7:0]  settle_cnt;
  logic [7:0]  exit_cnt;
  logic [7:0]  sync_tmr;
  logic [1:0]  sym_cnt;
  logic        errsotsync_q;

  logic lane_clr;
  logic lane_cap;
  logic byte_load;
  logic match0;
  logic all_match;
  logic part_match;

  // Lane control: clear on the last SETTLE edge, shift in SYNC/HS, and load
  // the byte register on the 4th symbol of a byte while the burst is alive.
  assign lane_clr  = (state == DPHY_ST_SETTLE) && hs_active && (settle_cnt <= 8'd1);
  assign lane_cap  = (state == DPHY_ST_SYNC) || (state == DPHY_ST_HS);
  assign byte_load = (state == DPHY_ST_HS) && hs_active && (sym_cnt == 2'd3);

  dphy_rx_lane #(.SYNC_BYTE(SYNC_BYTE)) u_lane0 (
    .byteclk   (byteclk),
    .resetn    (resetn),
    .clr       (lane_clr),
    .cap_en    (lane_cap),
    .byte_en   (byte_load),
    .d         (D0),
    .match     (match0),
    .lane_byte (lane0_byte)
  );

`ifdef DPHY_RX_LANE1_EN
  logic match1;

  dphy_rx_lane #(.SYNC_BYTE(SYNC_BYTE)) u_lane1 (
    .byteclk   (byteclk),
    .resetn    (resetn),
    .clr       (lane_clr),
    .cap_en    (lane_cap),
    .byte_en   (byte_load),
    .d         (D1),
    .match     (match1),
    .lane_byte (lane1_byte)
  );

  assign all_match     = match0 && match1;
  assign part_match    = match0 ^ match1;
  assign errsotsync_hs = errsotsync_q;
`else
  logic unused_lane1;

  assign all_match     = match0;
  assign part_match    = 1'b0;
  assign lane1_byte    = 8'h00;
  assign errsotsync_hs = 1'b0;
  assign unused_lane1  = ^{D1, errsotsync_q};
`endif

  // Link FSM with settle/exit/sync down-counters and registered status pulses.
  always_ff @(posedge byteclk) begin
    if (!resetn) begin
      state        <= DPHY_ST_LP;
      settle_cnt   <= 8'd0;
      exit_cnt     <= 8'd0;
      sync_tmr     <= 8'd0;
      sym_cnt      <= 2'd0;
      rxactive_hs  <= 1'b0;
      rxsync_hs    <= 1'b0;
      rxvalid_hs   <= 1'b0;
      errsoths_hs  <= 1'b0;
      errsotsync_q <= 1'b0;
    end else begin
      rxsync_hs    <= 1'b0;
      rxvalid_hs   <= 1'b0;
      errsoths_hs  <= 1'b0;
      errsotsync_q <= 1'b0;
      // Registered view of the state, so it trails SYNC entry / EXIT entry by one cycle.
      rxactive_hs  <= (state == DPHY_ST_SYNC) || (state == DPHY_ST_HS);

      case (state)
        DPHY_ST_LP: begin
          if (hs_clk_active && hs_active) begin
            state      <= DPHY_ST_SETTLE;
            settle_cnt <= 8'(SETTLE_CYC);
          end
        end

        DPHY_ST_SETTLE: begin
          if (!hs_active) begin
            state    <= DPHY_ST_EXIT;
            exit_cnt <= 8'(EXIT_CYC);
          end else if (settle_cnt <= 8'd1) begin
            state      <= DPHY_ST_SYNC;
            settle_cnt <= 8'd0;
            sync_tmr   <= 8'(SYNC_TIMEOUT);
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end

        DPHY_ST_SYNC: begin
          // A falling hs_active beats a sync match sampled on the same edge.
          if (!hs_active) begin
            state    <= DPHY_ST_EXIT;
            exit_cnt <= 8'(EXIT_CYC);
          end else if (all_match) begin
            state     <= DPHY_ST_HS;
            rxsync_hs <= 1'b1;
            sym_cnt   <= 2'd0;
          end else if (part_match) begin
            state        <= DPHY_ST_EXIT;
            exit_cnt     <= 8'(EXIT_CYC);
            errsotsync_q <= 1'b1;
          end else if (sync_tmr <= 8'd1) begin
            state       <= DPHY_ST_EXIT;
            exit_cnt    <= 8'(EXIT_CYC);
            errsoths_hs <= 1'b1;
          end else begin
            sync_tmr <= sync_tmr - 8'd1;
          end
        end

        DPHY_ST_HS: begin
          // A partial byte at the end of the burst is simply dropped.
          if (!hs_active) begin
            state    <= DPHY_ST_EXIT;
            exit_cnt <= 8'(EXIT_CYC);
            sym_cnt  <= 2'd0;
          end else begin
            sym_cnt <= sym_cnt + 2'd1;
            if (sym_cnt == 2'd3) begin
              rxvalid_hs <= 1'b1;
            end
          end
        end

        DPHY_ST_EXIT: begin
          if (hs_active || (exit_cnt != 8'd0)) begin
            if (exit_cnt != 8'd0) begin
              exit_cnt <= exit_cnt - 8'd1;
            end
          end else begin
            state <= DPHY_ST_LP;
          end
        end

        default: begin
          state <= DPHY_ST_LP;
        end
      endcase
    end
  end

endmodule
